// File: rtl/mem_stage.sv
// Pipeline MEM stage: word-addressed data RAM, LATENCY cycles per aligned load/store, 1 cycle otherwise.
// Stalls upstream combinationally in IDLE on a memory op and then from registered state while BUSY.
module mem_stage #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        MemRead_In,
  input  logic        MemWrite_In,
  input  logic        RegWrite_In,
  input  logic        MemtoReg_Select_In,
  input  logic [31:0] aluResult_In,
  input  logic [31:0] writeData_In,
  input  logic [4:0]  writeReg_In,
  output logic        stall,
  output logic        valid_out,
  output logic        RegWrite_Out,
  output logic        MemtoReg_Select_Out,
  output logic [31:0] readDataMem_Out,
  output logic [31:0] aluResult_Out,
  output logic [4:0]  writeReg_Out,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   mem [DEPTH];

  logic        cap_write, cap_regwrite, cap_memtoreg;
  logic [31:0] cap_alu, cap_wdata;
  logic [4:0]  cap_wreg;

  logic        is_mem, is_mis, mem_ok;
  logic        start, complete;
  logic        f_write, f_regwrite, f_memtoreg;
  logic [31:0] f_alu, f_wdata;
  logic [4:0]  f_wreg;
  logic [AW-1:0] f_idx;

  assign is_mem = valid_in & (MemRead_In | MemWrite_In);
  assign is_mis = is_mem & (aluResult_In[1:0] != 2'b00);
  assign mem_ok = is_mem & ~is_mis;
  assign f_idx  = f_alu[AW+1:2];

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    stall      = 1'b0;
    start      = 1'b0;
    complete   = 1'b0;
    f_write    = MemWrite_In;
    f_regwrite = RegWrite_In;
    f_memtoreg = MemtoReg_Select_In;
    f_alu      = aluResult_In;
    f_wdata    = writeData_In;
    f_wreg     = writeReg_In;
    case (state)
      IDLE: begin
        if (mem_ok) begin
          if (LATENCY == 1) begin
            complete = 1'b1;
          end else begin
            start     = 1'b1;
            stall     = 1'b1;
            state_nxt = BUSY;
            cnt_nxt   = CW'(1);
          end
        end
      end
      BUSY: begin
        // Upstream is frozen; work only from the captured instruction.
        f_write    = cap_write;
        f_regwrite = cap_regwrite;
        f_memtoreg = cap_memtoreg;
        f_alu      = cap_alu;
        f_wdata    = cap_wdata;
        f_wreg     = cap_wreg;
        if (cnt == CNT_LAST) begin
          complete  = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          stall   = 1'b1;
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      cnt                 <= '0;
      valid_out           <= 1'b0;
      RegWrite_Out        <= 1'b0;
      MemtoReg_Select_Out <= 1'b0;
      readDataMem_Out     <= '0;
      aluResult_Out       <= '0;
      writeReg_Out        <= '0;
      misaligned          <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (start) begin
        cap_write    <= MemWrite_In;
        cap_regwrite <= RegWrite_In;
        cap_memtoreg <= MemtoReg_Select_In;
        cap_alu      <= aluResult_In;
        cap_wdata    <= writeData_In;
        cap_wreg     <= writeReg_In;
      end
      if (complete) begin
        valid_out           <= 1'b1;
        RegWrite_Out        <= f_regwrite;
        MemtoReg_Select_Out <= f_memtoreg;
        aluResult_Out       <= f_alu;
        writeReg_Out        <= f_wreg;
        misaligned          <= 1'b0;
        readDataMem_Out     <= f_write ? 32'h0 : mem[f_idx];
      end else if (stall) begin
        // Bubble to MEM/WB; data outputs keep their last values.
        valid_out    <= 1'b0;
        RegWrite_Out <= 1'b0;
        misaligned   <= 1'b0;
      end else begin
        valid_out           <= valid_in;
        RegWrite_Out        <= valid_in & RegWrite_In & ~is_mis;
        MemtoReg_Select_Out <= MemtoReg_Select_In;
        aluResult_Out       <= aluResult_In;
        writeReg_Out        <= writeReg_In;
        readDataMem_Out     <= 32'h0;
        misaligned          <= is_mis;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && complete && f_write) mem[f_idx] <= f_wdata;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, between the EX/MEM register and the MEM/WB register. It takes an instruction's ALU result, store data and control bits from EX/MEM and performs the data-memory access against an internal word-addressed RAM with a fixed multi-cycle latency. It stalls the front of the pipeline while an access is in progress. Registered results go to the MEM/WB register inputs, qualified by `valid_out`.

## Interface
- `DEPTH`, 64: data-memory size in 32-bit words; power of two.
- `LATENCY`, 2: cycles per memory op (≥1); non-memory ops always take 1.

Ports:
- `clk`: in, 1, rising-edge clock.
- `reset`: in, 1, synchronous, active-high.
- `valid_in`: in, 1, EX/MEM holds a real instruction.
- `MemRead_In`: in, 1, load.
- `MemWrite_In`: in, 1, store.
- `RegWrite_In`: in, 1, passed to WB.
- `MemtoReg_Select_In`: in, 1, passed to WB.
- `aluResult_In`: in, 32, byte address or ALU result.
- `writeData_In`: in, 32, store data.
- `writeReg_In`: in, 5, destination register.
- `stall`: out, 1, freeze PC/IF/ID/EX/MEM this cycle.
- `valid_out`: out, 1, outputs carry a retiring instruction.
- `RegWrite_Out`: out, 1.
- `MemtoReg_Select_Out`: out, 1.
- `readDataMem_Out`: out, 32, load data.
- `aluResult_Out`: out, 32.
- `writeReg_Out`: out, 5.
- `misaligned`: out, 1, memory op with `aluResult_In[1:0]` not equal to 0; valid with `valid_out`.

## Operation
- Memory index = `aluResult_In[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- FSM states: IDLE, BUSY. Counter `cnt` has width ≥ log2(LATENCY)+1.
- A memory op is `valid_in & (MemRead_In | MemWrite_In)` with aligned address.
- **IDLE, non-memory op or bubble:** retires in 1 cycle.
  - Outputs take the inputs.
  - `readDataMem_Out` = 0.
  - `valid_out` = `valid_in`.
  - On a bubble, `RegWrite_Out` is forced to 0.
- **IDLE, misaligned memory op:** retires in 1 cycle.
  - No memory read or write.
  - `misaligned` = 1, `RegWrite_Out` = 0, `readDataMem_Out` = 0.
- **IDLE, memory op, LATENCY = 1:** completes in the same cycle as below, no stall.
- **IDLE, memory op, LATENCY > 1:**
  - Capture all input fields internally.
  - `cnt` ← 1, go to BUSY.
  - `stall` = 1 combinationally in this cycle.
- **BUSY:**
  - Inputs are ignored and the captured fields are used.
  - `stall` = 1 while `cnt` < LATENCY−1.
  - When `cnt` = LATENCY−1: `stall` = 0. At the next edge, complete, return to IDLE, and `cnt` ← 0.
- **Completion edge:**
  - Store: `mem[idx]` ← data, `readDataMem_Out` = 0.
  - Load: `readDataMem_Out` = `mem[idx]`, which reflects all earlier completed stores.
  - `valid_out` = 1. Control, `aluResult`, and `writeReg` outputs are taken from the captured fields.
- `MemRead_In` and `MemWrite_In` both set: treated as a store.
- While stalled, `valid_out` = 0 and `RegWrite_Out` = 0, so the stage sends bubbles to MEM/WB. Data outputs hold their values.
- `misaligned` is 0 unless set by a retiring misaligned op.

## Timing
- Reset values:
  - State IDLE, `cnt` = 0.
  - `stall`, `valid_out`, `RegWrite_Out`, `MemtoReg_Select_Out`, `misaligned` = 0.
  - `readDataMem_Out`, `aluResult_Out`, `writeReg_Out` = 0.
- RAM contents are not reset and are undefined at power-up.
- Reset in BUSY aborts the op: no memory write and no retirement. `stall` drops in the cycle reset is asserted.
- A non-memory op accepted in cycle T has its outputs visible in T+1.
- A memory op accepted at T:
  - `stall` is high in T … T+LATENCY−2.
  - Outputs are visible in T+LATENCY.
  - Upstream is released in T+LATENCY−1 and presents the next instruction in T+LATENCY.
- Back-to-back memory ops: the next op enters IDLE handling in the cycle right after completion, with no dead cycle.
- `stall` depends combinationally on `valid_in`/`MemRead_In`/`MemWrite_In`/`aluResult_In[1:0]` in IDLE, and only on registered state in BUSY.

## Test plan
- **Reset:** LATENCY=3. Assert `reset` for 2 cycles with a memory op on the inputs → all outputs 0, `stall` 0 throughout.
- **Store then load:** store 0xDEADBEEF at address 0x10, then load 0x10 into r9.
  - Each op: `stall` high 2 cycles, then `valid_out`=1.
  - Load retires with `readDataMem_Out`=0xDEADBEEF, `writeReg_Out`=9, `RegWrite_Out`=1.
- **ALU pass-through:** `valid_in`=1, no memory op, `aluResult_In`=0x1234, r3 → next cycle `aluResult_Out`=0x1234, `writeReg_Out`=3, `valid_out`=1, `stall` never high.
- **Misaligned load:** load at address 0x22 → no stall. Next cycle `misaligned`=1, `RegWrite_Out`=0, `readDataMem_Out`=0. Memory unchanged (verified by a later aligned load).
- **Wrap-around:** DEPTH=64. Store 0x55 to 0x104 (index 1), then load from 0x004 → 0x55.
- **Reset mid-access:** store 0xAA to 0x8, assert `reset` in its second BUSY cycle, then load 0x8 → previous contents returned, not 0xAA, with no `valid_out` pulse for the aborted store.
